weight_bram_reader: RTL



---
 rtl/weight_bram_reader_if.sv | 26 ++
 rtl/weight_bram_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_reader_if.sv
// Port bundle for weight_bram_reader: the BRAM read port and the weight stream.
// The master side is the reader; the slave side is the BRAM plus the MAC sink.
interface weight_bram_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0] W_DATA;
    logic              W_VALID;
    logic              W_READY;
    logic              W_LAST;
    logic [ADDR_W-1:0] W_INDEX;

    modport master (
        output BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_VALID, W_LAST, W_INDEX,
        input  BRAM_DO, W_READY
    );

    modport slave (
        input  BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_VALID, W_LAST, W_INDEX,
        output BRAM_DO, W_READY
    );
endinterface

// File: rtl/weight_bram_reader.sv
// Read-side sequencer for one weight BRAM. A START pulse walks addresses
// 0..DEPTH-1 once, pushes each returned word into a 2-entry output FIFO and
// streams it to the MAC on a valid/ready handshake.
// Optional build macro WEIGHT_CHECKSUM_EN adds a per-pass CHECKSUM output.
module weight_bram_reader #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    output logic                BUSY,
    output logic                DONE,
`ifdef WEIGHT_CHECKSUM_EN
    output logic [DATA_W-1:0]   CHECKSUM,
`endif
    weight_bram_reader_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    // One FIFO slot: the weight plus the tags that travel with it.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              done_pend_q, done_pend_d;
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    entry_t            ent0_q, ent0_d;   // FIFO head, drives the stream
    entry_t            ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;
`ifdef WEIGHT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    logic   push;
    logic   pop;
    entry_t incoming;

    // The read issued on the previous edge returns its word on this edge.
    assign push = bram_en_q;
    assign pop  = (count_q != 2'd0) && bus.W_READY;

    // Word arriving from the BRAM, tagged with the address it was read from.
    always_comb begin
        incoming.data  = bus.BRAM_DO;
        incoming.index = bram_addr_q;
        incoming.last  = (bram_addr_q == LAST_ADDR);
    end

    // Output FIFO: push/pop bookkeeping, head always in ent0.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = incoming;
                else                 ent1_d = incoming;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever stays.
                if (count_q == 2'd1) begin
                    ent0_d = incoming;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = incoming;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: start/issue/drain control and the registered status outputs.
    always_comb begin
        state_d      = state_q;
        issue_addr_d = issue_addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        done_pend_d  = done_pend_q;
        bram_en_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
`ifdef WEIGHT_CHECKSUM_EN
        checksum_d   = pop ? (checksum_q + ent0_q.data) : checksum_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // A START coinciding with the DONE pulse is not a new pass.
                if (START && !done_q) begin
                    state_d      = FETCH;
                    issue_addr_d = '0;
                    done_pend_d  = 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                end
            end
            FETCH: begin
                busy_d = 1'b1;
                // Credit: occupancy after this edge already counts the word in flight.
                if (count_d != 2'd2) begin
                    bram_en_d    = 1'b1;
                    bram_addr_d  = issue_addr_q;
                    issue_addr_d = issue_addr_q + ADDR_W'(1);
                    if (issue_addr_q == LAST_ADDR) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (done_pend_q) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    done_pend_d = 1'b0;
                    state_d     = IDLE;
                end else if (pop && ent0_q.last) begin
                    done_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any pass and drops the word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            issue_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pend_q  <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            // NOTE: FIFO storage is reset as well, so W_DATA/W_INDEX/W_LAST read 0 out of reset.
            ent0_q       <= '0;
            ent1_q       <= '0;
            count_q      <= 2'd0;
`ifdef WEIGHT_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            issue_addr_q <= issue_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_pend_q  <= done_pend_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            count_q      <= count_d;
`ifdef WEIGHT_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign bus.BRAM_EN   = bram_en_q;
    assign bus.BRAM_ADDR = bram_addr_q;
    assign bus.BRAM_WE   = 1'b0;
    assign bus.W_VALID   = (count_q != 2'd0);
    assign bus.W_DATA    = ent0_q.data;
    assign bus.W_INDEX   = ent0_q.index;
    assign bus.W_LAST    = ent0_q.last;
`ifdef WEIGHT_CHECKSUM_EN
    assign CHECKSUM      = checksum_q;
`endif

endmodule
